// File: rtl/tick_timer_if.sv
// Control/status bundle between a tick_timer and the logic that programs it.
// The slave side is the timer itself; the master side drives the controls.
interface tick_timer_if #(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned FIRE_W = 4
);
   logic              tick;
   logic              in_valid;
   logic [CNT_W-1:0]  in_period;
   logic              start;
   logic              pause;
   logic              stop;
   logic              auto_reload;
   logic              out_valid;
   logic              busy;
   logic [CNT_W-1:0]  count;
   logic [FIRE_W-1:0] fire_cnt;

   modport master (
      output tick, in_valid, in_period, start, pause, stop, auto_reload,
      input  out_valid, busy, count, fire_cnt
   );

   modport slave (
      input  tick, in_valid, in_period, start, pause, stop, auto_reload,
      output out_valid, busy, count, fire_cnt
   );
endinterface

// File: rtl/tick_timer.sv
// Programmable countdown timer clocked by divider tick pulses, with one-cycle
// expiry pulse, optional auto-reload, pause hold and abort.
module tick_timer #(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned FIRE_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   tick_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [FIRE_W-1:0]  fire_q, fire_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q;
   logic [CNT_W-1:0]   eff_period;

   // A load in the same cycle as start takes effect for that start.
   assign eff_period = bus.in_valid ? bus.in_period : period_q;

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      count_d     = count_q;
      fire_d      = fire_q;
      out_valid_d = 1'b0;

      if (bus.stop) begin
         state_d = IDLE;
         count_d = '0;
         fire_d  = '0;
      end else begin
         if (bus.in_valid) begin
            period_d = bus.in_period;
         end

         unique case (state_q)
            IDLE, DONE: begin
               if (bus.start && (eff_period != '0)) begin
                  count_d = eff_period;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_d = HOLD;
               end else if (bus.tick) begin
                  if (count_q > CNT_W'(1)) begin
                     count_d = count_q - CNT_W'(1);
                  end else if (count_q == CNT_W'(1)) begin
                     out_valid_d = 1'b1;
                     fire_d      = fire_q + FIRE_W'(1);
                     // Reload uses the period held before any same-cycle load.
                     if (bus.auto_reload && (period_q != '0)) begin
                        count_d = period_q;
                     end else begin
                        count_d = '0;
                        state_d = DONE;
                     end
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            HOLD: begin
               if (!bus.pause) begin
                  state_d = RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         period_q    <= '0;
         count_q     <= '0;
         fire_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         count_q     <= count_d;
         fire_q      <= fire_d;
         out_valid_q <= out_valid_d;
         busy_q      <= (state_d == RUN) || (state_d == HOLD);
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.count     = count_q;
   assign bus.fire_cnt  = fire_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus a randomized run,
// all checked against a behavioural model of the timer's rules.
module tb_tick_timer;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned FIRE_W = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   tick_timer_if #(.CNT_W(CNT_W), .FIRE_W(FIRE_W)) tif ();

   tick_timer #(.CNT_W(CNT_W), .FIRE_W(FIRE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: "active" covers counting or paused, count is a plain int.
   int m_per;
   int m_cnt;
   int m_fires;
   bit m_active;
   bit m_paused;
   bit m_ov;

   task automatic model_reset();
      m_per = 0; m_cnt = 0; m_fires = 0;
      m_active = 0; m_paused = 0; m_ov = 0;
   endtask

   task automatic model_edge();
      int newp;
      m_ov = 0;
      if (tif.stop) begin
         m_active = 0; m_paused = 0; m_cnt = 0; m_fires = 0;
      end else begin
         newp = tif.in_valid ? int'(tif.in_period) : m_per;
         if (!m_active) begin
            if (tif.start && newp != 0) begin
               m_active = 1; m_paused = 0; m_cnt = newp;
            end
         end else if (m_paused) begin
            if (!tif.pause) m_paused = 0;
         end else if (tif.pause) begin
            m_paused = 1;
         end else if (tif.tick) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_ov = 1;
               m_fires = (m_fires + 1) % (1 << FIRE_W);
               if (tif.auto_reload && m_per != 0) m_cnt = m_per;
               else m_active = 0;
            end
         end
         m_per = newp;
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_pulses();
      tif.tick = 0; tif.in_valid = 0; tif.start = 0; tif.stop = 0;
   endtask

   task automatic do_stop();
      tif.stop = 1; clk_step(); clear_pulses();
   endtask

   task automatic load_start(input int p);
      tif.in_valid = 1; tif.in_period = CNT_W'(p); tif.start = 1;
      clk_step(); clear_pulses();
   endtask

   task automatic test_reset();
      total++;
      if (tif.out_valid !== 1'b0 || tif.busy !== 1'b0 || tif.count !== '0 || tif.fire_cnt !== '0) begin
         bad++;
         $display("FAIL reset: ov=%b busy=%b count=%0d fire=%0d required all 0",
                  tif.out_valid, tif.busy, tif.count, tif.fire_cnt);
      end
   endtask

   task automatic test_basic();
      int pulses = 0;
      do_stop();
      tif.auto_reload = 0;
      load_start(3);
      total++;
      if (tif.count !== 8'd3 || tif.busy !== 1'b1) begin
         bad++; $display("FAIL basic_start: count=%0d busy=%b required 3 1", tif.count, tif.busy);
      end
      for (int k = 1; k <= 3; k++) begin
         tif.tick = 1; clk_step(); tif.tick = 0;
         if (tif.out_valid) pulses++;
         total++;
         if (tif.count !== CNT_W'(3 - k) || tif.out_valid !== (k == 3)) begin
            bad++; $display("FAIL basic_tick%0d: count=%0d ov=%b required %0d %b",
                            k, tif.count, tif.out_valid, 3 - k, k == 3);
         end
         clk_step();
         if (tif.out_valid) pulses++;
      end
      total++;
      if (pulses != 1 || tif.busy !== 1'b0 || tif.fire_cnt !== 4'd1) begin
         bad++; $display("FAIL basic_done: pulses=%0d busy=%b fire=%0d required 1 0 1",
                         pulses, tif.busy, tif.fire_cnt);
      end
   endtask

   task automatic test_auto_reload();
      int pulses = 0;
      do_stop();
      tif.auto_reload = 1;
      load_start(2);
      for (int k = 1; k <= 6; k++) begin
         tif.tick = 1; clk_step(); tif.tick = 0;
         if (tif.out_valid) pulses++;
         total++;
         if (tif.out_valid !== (k % 2 == 0) || tif.count !== ((k % 2 == 0) ? 8'd2 : 8'd1)
             || tif.busy !== 1'b1) begin
            bad++; $display("FAIL reload_tick%0d: ov=%b count=%0d busy=%b required %b %0d 1",
                            k, tif.out_valid, tif.count, tif.busy, k % 2 == 0,
                            (k % 2 == 0) ? 2 : 1);
         end
      end
      total++;
      if (pulses != 3 || tif.fire_cnt !== 4'd3) begin
         bad++; $display("FAIL reload_fire: pulses=%0d fire=%0d required 3 3", pulses, tif.fire_cnt);
      end
      tif.auto_reload = 0;
      do_stop();
   endtask

   task automatic test_pause();
      int pulses = 0;
      do_stop();
      tif.auto_reload = 0;
      load_start(5);
      tif.tick = 1; clk_step(); clk_step();
      tif.pause = 1; clk_step(); tif.tick = 0;
      for (int k = 0; k < 4; k++) begin
         tif.tick = 1; clk_step(); tif.tick = 0; clk_step();
         if (tif.out_valid) pulses++;
         total++;
         if (tif.count !== 8'd3 || tif.busy !== 1'b1) begin
            bad++; $display("FAIL pause_hold%0d: count=%0d busy=%b required 3 1", k, tif.count, tif.busy);
         end
      end
      tif.pause = 0; clk_step();
      for (int k = 1; k <= 3; k++) begin
         tif.tick = 1; clk_step(); tif.tick = 0;
         if (tif.out_valid) pulses++;
      end
      clk_step();
      if (tif.out_valid) pulses++;
      total++;
      if (pulses != 1 || tif.count !== 8'd0 || tif.busy !== 1'b0) begin
         bad++; $display("FAIL pause_expiry: pulses=%0d count=%0d busy=%b required 1 0 0",
                         pulses, tif.count, tif.busy);
      end
   endtask

   task automatic test_shadow_zero();
      do_stop();
      tif.auto_reload = 1;
      load_start(4);
      tif.tick = 1; clk_step(); tif.tick = 0;
      tif.in_valid = 1; tif.in_period = 8'd7; clk_step(); clear_pulses();
      total++;
      if (tif.count !== 8'd3 || tif.out_valid !== 1'b0) begin
         bad++; $display("FAIL shadow_keep: count=%0d ov=%b required 3 0", tif.count, tif.out_valid);
      end
      tif.tick = 1; clk_step(); clk_step(); clk_step(); tif.tick = 0;
      total++;
      if (tif.out_valid !== 1'b1 || tif.count !== 8'd7) begin
         bad++; $display("FAIL shadow_reload: ov=%b count=%0d required 1 7", tif.out_valid, tif.count);
      end
      tif.auto_reload = 0;
      do_stop();
      load_start(0);
      total++;
      if (tif.busy !== 1'b0 || tif.count !== 8'd0) begin
         bad++; $display("FAIL zero_period: busy=%b count=%0d required 0 0", tif.busy, tif.count);
      end
   endtask

   task automatic test_stop_reset();
      do_stop();
      tif.auto_reload = 0;
      load_start(1);
      tif.tick = 1; clk_step(); tif.tick = 0;
      load_start(5);
      tif.tick = 1; clk_step(); clk_step(); clk_step(); tif.tick = 0;
      total++;
      if (tif.count !== 8'd2 || tif.fire_cnt !== 4'd1) begin
         bad++; $display("FAIL stop_pre: count=%0d fire=%0d required 2 1", tif.count, tif.fire_cnt);
      end
      do_stop();
      total++;
      if (tif.busy !== 1'b0 || tif.count !== 8'd0 || tif.fire_cnt !== 4'd0 || tif.out_valid !== 1'b0) begin
         bad++; $display("FAIL stop: busy=%b count=%0d fire=%0d ov=%b required 0 0 0 0",
                         tif.busy, tif.count, tif.fire_cnt, tif.out_valid);
      end
      tif.start = 1; clk_step(); tif.start = 0;
      tif.tick = 1; clk_step(); tif.tick = 0;
      total++;
      if (tif.count !== 8'd4 || tif.busy !== 1'b1) begin
         bad++; $display("FAIL restart_kept_period: count=%0d busy=%b required 4 1", tif.count, tif.busy);
      end
      #1 rst = 1;
      #1;
      model_reset();
      total++;
      if (tif.out_valid !== 1'b0 || tif.busy !== 1'b0 || tif.count !== '0 || tif.fire_cnt !== '0) begin
         bad++; $display("FAIL async_reset: ov=%b busy=%b count=%0d fire=%0d required all 0",
                         tif.out_valid, tif.busy, tif.count, tif.fire_cnt);
      end
      @(negedge clk) rst = 0;
      tif.start = 1; clk_step(); tif.start = 0;
      total++;
      if (tif.busy !== 1'b0) begin
         bad++; $display("FAIL reset_period_cleared: busy=%b required 0", tif.busy);
      end
   endtask

   task automatic test_wrap();
      int pulses = 0;
      do_stop();
      tif.auto_reload = 1;
      load_start(1);
      for (int k = 1; k <= 16; k++) begin
         tif.tick = 1; clk_step();
         if (tif.out_valid) pulses++;
         if (k == 15) begin
            total++;
            if (tif.fire_cnt !== 4'd15) begin
               bad++; $display("FAIL wrap_15: fire=%0d required 15", tif.fire_cnt);
            end
         end
      end
      tif.tick = 0;
      total++;
      if (pulses != 16 || tif.fire_cnt !== 4'd0 || tif.count !== 8'd1) begin
         bad++; $display("FAIL wrap_16: pulses=%0d fire=%0d count=%0d required 16 0 1",
                         pulses, tif.fire_cnt, tif.count);
      end
      tif.auto_reload = 0;
      do_stop();
   endtask

   task automatic test_random();
      int errs = 0;
      for (int n = 0; n < 3000; n++) begin
         tif.tick      = ($urandom_range(0, 1) == 1);
         tif.in_valid  = ($urandom_range(0, 9) == 0);
         tif.in_period = CNT_W'($urandom_range(0, 6));
         tif.start     = ($urandom_range(0, 6) == 0);
         tif.stop      = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 9) == 0) tif.pause = ~tif.pause;
         if ($urandom_range(0, 19) == 0) tif.auto_reload = ~tif.auto_reload;
         clk_step();
         total++;
         if (tif.out_valid !== m_ov || tif.busy !== m_active || tif.count !== CNT_W'(m_cnt)
             || tif.fire_cnt !== FIRE_W'(m_fires)) begin
            bad++;
            if (errs < 10)
               $display("FAIL random_cyc%0d: ov=%b busy=%b count=%0d fire=%0d required %b %b %0d %0d",
                        n, tif.out_valid, tif.busy, tif.count, tif.fire_cnt,
                        m_ov, m_active, m_cnt, m_fires);
            errs++;
         end
      end
      clear_pulses();
      tif.pause = 0;
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1;
      tif.tick = 0; tif.in_valid = 0; tif.in_period = '0; tif.start = 0;
      tif.pause = 0; tif.stop = 0; tif.auto_reload = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      test_reset();
      test_basic();
      test_auto_reload();
      test_pause();
      test_shadow_zero();
      test_stop_reset();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
